// File: rtl/apb_pkg.sv
// Shared types and default parameters for the APB master controller.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DERR   = 2'd3
  } apb_state_e;

  localparam int APB_ADDR_W  = 32;
  localparam int APB_DATA_W  = 32;
  localparam int APB_NUM_SLV = 4;
  localparam int APB_SLV_LSB = 28;
  localparam int APB_TIMEOUT = 16;

  // Select-field width; a single slave still needs a 1-bit index vector.
  function automatic int sel_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_master_ctrl_if.sv
// Request/response handshake plus APB bus signals of the controller.
interface apb_master_ctrl_if #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 4
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_write;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  logic [ADDR_W-1:0]  Paddr;
  logic [DATA_W-1:0]  Pwdata;
  logic               Pwrite;
  logic [NUM_SLV-1:0] Pselx;
  logic               Penable;
  logic [DATA_W-1:0]  Prdata;
  logic               Pready;
  logic               Pslverr;

  modport master (
    input  req_valid, req_addr, req_write, req_wdata, Prdata, Pready, Pslverr,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           Paddr, Pwdata, Pwrite, Pselx, Penable
  );

  modport slave (
    output req_valid, req_addr, req_write, req_wdata, Prdata, Pready, Pslverr,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           Paddr, Pwdata, Pwrite, Pselx, Penable
  );
endinterface

// File: rtl/apb_addr_decode.sv
// Address to one-hot slave select; err flags an index with no slave behind it.
module apb_addr_decode
  import apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int NUM_SLV = APB_NUM_SLV,
  parameter int SLV_LSB = APB_SLV_LSB
) (
  input  logic [ADDR_W-1:0]  addr,
  output logic [NUM_SLV-1:0] sel,
  output logic               err
);
  localparam int SW = sel_bits(NUM_SLV);

  logic [SW-1:0] idx;
  logic          unused_addr;

  generate
    if (NUM_SLV == 1) begin : g_one
      assign idx = '0;
    end else begin : g_many
      assign idx = addr[SLV_LSB +: SW];
    end
  endgenerate

  assign unused_addr = ^addr;

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_SLV; i++) sel[i] = (idx == SW'(i));
  end

  // Indices past NUM_SLV leave sel empty.
  assign err = ~|sel;

endmodule

// File: rtl/apb_master_ctrl.sv
// Single-request APB master: accepts a request, runs SETUP/ACCESS with wait
// states and timeout, and returns a one-cycle response pulse.
module apb_master_ctrl
  import apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int NUM_SLV = APB_NUM_SLV,
  parameter int SLV_LSB = APB_SLV_LSB,
  parameter int TIMEOUT = APB_TIMEOUT
) (
  input logic             clock,
  input logic             reset,
  apb_master_ctrl_if.master bus
);
  localparam int CW = $clog2(TIMEOUT);

  apb_state_e         state;
  logic               rdy_q;
  logic [CW-1:0]      wcnt;
  logic [NUM_SLV-1:0] dec_sel;
  logic               dec_err;
  logic               ready;
  logic               take;

  logic               rsp_valid_q;
  logic [DATA_W-1:0]  rsp_rdata_q;
  logic               rsp_err_q;
  logic [ADDR_W-1:0]  paddr_q;
  logic [DATA_W-1:0]  pwdata_q;
  logic               pwrite_q;
  logic [NUM_SLV-1:0] psel_q;
  logic               penable_q;

  apb_addr_decode #(
    .ADDR_W (ADDR_W),
    .NUM_SLV(NUM_SLV),
    .SLV_LSB(SLV_LSB)
  ) u_dec (
    .addr(bus.req_addr),
    .sel (dec_sel),
    .err (dec_err)
  );

  // rdy_q covers IDLE; the ACCESS term lets a new request ride the completing cycle.
  assign ready = rdy_q | ((state == ACCESS) & bus.Pready);
  assign take  = ready & bus.req_valid;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      rdy_q       <= 1'b0;
      wcnt        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      psel_q      <= '0;
      penable_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      rdy_q       <= 1'b0;
      case (state)
        IDLE: rdy_q <= ~take;
        SETUP: begin
          penable_q <= 1'b1;
          state     <= ACCESS;
        end
        ACCESS: begin
          if (bus.Pready) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= bus.Pslverr;
            rsp_rdata_q <= pwrite_q ? '0 : bus.Prdata;
            penable_q   <= 1'b0;
            if (!bus.req_valid) begin
              state  <= IDLE;
              psel_q <= '0;
              rdy_q  <= 1'b1;
            end
          end else if (wcnt == CW'(TIMEOUT - 1)) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= '0;
            penable_q   <= 1'b0;
            psel_q      <= '0;
            state       <= IDLE;
            rdy_q       <= 1'b1;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        DERR: begin
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b1;
          rsp_rdata_q <= '0;
          state       <= IDLE;
          rdy_q       <= 1'b1;
        end
        default: state <= IDLE;
      endcase

      // Acceptance overrides the per-state next state chosen above.
      if (take) begin
        paddr_q   <= bus.req_addr;
        pwdata_q  <= bus.req_wdata;
        pwrite_q  <= bus.req_write;
        penable_q <= 1'b0;
        wcnt      <= '0;
        if (dec_err) begin
          psel_q <= '0;
          state  <= DERR;
        end else begin
          psel_q <= dec_sel;
          state  <= SETUP;
        end
      end
    end
  end

  assign bus.req_ready = ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.Paddr     = paddr_q;
  assign bus.Pwdata    = pwdata_q;
  assign bus.Pwrite    = pwrite_q;
  assign bus.Pselx     = psel_q;
  assign bus.Penable   = penable_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Directed bench: table of single transfers on a 4-slave instance plus
// hand sequences for timeout, back-to-back, decode error and reset.
module tb_apb_master_ctrl;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  apb_master_ctrl_if #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(4)) if4 ();
  apb_master_ctrl_if #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(3)) if3 ();

  apb_master_ctrl #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(4), .SLV_LSB(28), .TIMEOUT(16)) u4 (
    .clock(clock), .reset(reset), .bus(if4)
  );
  apb_master_ctrl #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(3), .SLV_LSB(28), .TIMEOUT(16)) u3 (
    .clock(clock), .reset(reset), .bus(if3)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic        slverr;
    logic [31:0] prdata;
    logic [3:0]  exp_sel;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t tbl[6];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Slave-side noise that must never leak into a response.
  task automatic noise();
    if4.Pready  = 1'b0;
    if4.Pslverr = 1'b1;
    if4.Prdata  = 32'hFFFF_FFFF;
  endtask

  task automatic xfer(input vec_t v);
    chk("idle_ready", if4.req_ready, 1);
    if4.req_valid = 1'b1;
    if4.req_addr  = v.addr;
    if4.req_write = v.wr;
    if4.req_wdata = v.wdata;
    noise();
    tick();
    if4.req_valid = 1'b0;
    if4.req_addr  = 32'h5555_0000;
    if4.req_wdata = 32'h0;
    chk("setup_sel", if4.Pselx, v.exp_sel);
    chk("setup_pen", if4.Penable, 0);
    chk("setup_addr", if4.Paddr, v.addr);
    chk("setup_wr", if4.Pwrite, v.wr);
    chk("setup_wdata", if4.Pwdata, v.wdata);
    tick();
    chk("access_pen_sel", {if4.Penable, if4.Pselx}, {1'b1, v.exp_sel});
    for (int w = 0; w < v.waits; w++) begin
      tick();
      chk("wait_quiet", {if4.rsp_valid, if4.Penable, if4.Pselx}, {2'b01, v.exp_sel});
    end
    if4.Pready  = 1'b1;
    if4.Pslverr = v.slverr;
    if4.Prdata  = v.prdata;
    #1;
    chk("done_ready", if4.req_ready, 1);
    tick();
    noise();
    chk("rsp_valid", if4.rsp_valid, 1);
    chk("rsp_err", if4.rsp_err, v.exp_err);
    chk("rsp_rdata", if4.rsp_rdata, v.exp_rdata);
    chk("rsp_bus_idle", {if4.Pselx, if4.Penable}, 0);
    tick();
    chk("rsp_pulse", if4.rsp_valid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int bad_acc;
    //            wr    addr          wdata         w  serr  prdata        sel      err   rdata
    tbl[0] = '{1'b1, 32'h1000_0040, 32'hDEAD_BEEF, 0, 1'b0, 32'h0,        4'b0010, 1'b0, 32'h0};
    tbl[1] = '{1'b0, 32'h2000_0000, 32'h0,         3, 1'b0, 32'h1234_5678, 4'b0100, 1'b0, 32'h1234_5678};
    tbl[2] = '{1'b1, 32'h0000_0004, 32'h0BAD_F00D, 1, 1'b1, 32'h7777_7777, 4'b0001, 1'b1, 32'h0};
    tbl[3] = '{1'b0, 32'h3000_0010, 32'h0,         0, 1'b1, 32'hA5A5_5A5A, 4'b1000, 1'b1, 32'hA5A5_5A5A};
    tbl[4] = '{1'b0, 32'h0FFF_FFFC, 32'h0,         2, 1'b0, 32'hCAFE_F00D, 4'b0001, 1'b0, 32'hCAFE_F00D};
    tbl[5] = '{1'b0, 32'h1000_0000, 32'h0,        15, 1'b0, 32'h0BAD_CAFE, 4'b0010, 1'b0, 32'h0BAD_CAFE};

    if4.req_valid = 0; if4.req_addr = 0; if4.req_write = 0; if4.req_wdata = 0;
    if4.Prdata = 0; if4.Pready = 0; if4.Pslverr = 0;
    if3.req_valid = 0; if3.req_addr = 0; if3.req_write = 0; if3.req_wdata = 0;
    if3.Prdata = 0; if3.Pready = 0; if3.Pslverr = 0;

    // Reset state and first-edge ready.
    #3;
    chk("rst_outs", {if4.req_ready, if4.rsp_valid, if4.rsp_err, if4.Pselx, if4.Penable, if4.Pwrite}, 0);
    chk("rst_data", {if4.Paddr, if4.Pwdata}, 0);
    chk("rst_rdata", if4.rsp_rdata, 0);
    tick(); tick();
    reset = 1'b0;
    chk("rel_ready_low", if4.req_ready, 0);
    tick();
    chk("first_edge_ready", if4.req_ready, 1);

    for (int i = 0; i < 6; i++) xfer(tbl[i]);

    // Timeout: Pready held low for every ACCESS cycle.
    if4.req_valid = 1'b1; if4.req_addr = 32'h1000_0000; if4.req_write = 1'b0;
    noise();
    tick();
    if4.req_valid = 1'b0;
    bad_acc = 0;
    for (int c = 0; c < 16; c++) begin
      tick();
      if (!(if4.Penable === 1'b1 && if4.Pselx === 4'b0010 && if4.rsp_valid === 1'b0)) bad_acc++;
    end
    chk("to_access_16", bad_acc, 0);
    tick();
    chk("to_bus_clear", {if4.Pselx, if4.Penable}, 0);
    chk("to_rsp", {if4.rsp_valid, if4.rsp_err}, 2'b11);
    chk("to_rdata", if4.rsp_rdata, 0);
    chk("to_idle_ready", if4.req_ready, 1);
    tick();

    // Back-to-back writes.
    if4.req_valid = 1'b1; if4.req_addr = 32'h0000_0100; if4.req_write = 1'b1;
    if4.req_wdata = 32'hAAAA_0001;
    tick();
    if4.req_valid = 1'b0;
    tick();
    if4.Pready = 1'b1; if4.Pslverr = 1'b0;
    if4.req_valid = 1'b1; if4.req_addr = 32'h2000_0008; if4.req_wdata = 32'h1111_2222;
    #1;
    chk("b2b_ready", if4.req_ready, 1);
    tick();
    noise();
    if4.req_valid = 1'b0;
    chk("b2b_gap", {if4.rsp_valid, if4.rsp_err, if4.Penable, if4.Pselx}, {3'b100, 4'b0100});
    chk("b2b_addr", {if4.Paddr, if4.Pwdata}, {32'h2000_0008, 32'h1111_2222});
    tick();
    chk("b2b_access2", {if4.Penable, if4.rsp_valid}, 2'b10);
    if4.Pready = 1'b1; if4.Pslverr = 1'b0;
    tick();
    noise();
    chk("b2b_rsp2", {if4.rsp_valid, if4.rsp_err, if4.Pselx, if4.Penable}, {2'b10, 5'b0});
    tick();

    // Decode error on the 3-slave instance.
    chk("derr_idle_ready", if3.req_ready, 1);
    if3.req_valid = 1'b1; if3.req_addr = 32'h3000_0000; if3.req_write = 1'b0;
    tick();
    if3.req_valid = 1'b0;
    chk("derr_n1", {if3.Pselx, if3.Penable, if3.rsp_valid, if3.req_ready}, 0);
    tick();
    chk("derr_n2", {if3.rsp_valid, if3.rsp_err, if3.Pselx}, {2'b11, 3'b000});
    chk("derr_rdata", if3.rsp_rdata, 0);
    tick();
    chk("derr_ready_again", {if3.req_ready, if3.rsp_valid}, 2'b10);

    // Reset in ACCESS: outputs drop at once, no response.
    if4.req_valid = 1'b1; if4.req_addr = 32'h3000_0000; if4.req_write = 1'b1;
    if4.req_wdata = 32'h5A5A_5A5A;
    tick();
    if4.req_valid = 1'b0;
    tick();
    chk("rr_in_access", {if4.Penable, if4.Pselx}, 5'b11000);
    reset = 1'b1;
    #1;
    chk("rr_async_clear", {if4.Pselx, if4.Penable, if4.req_ready, if4.rsp_valid}, 0);
    chk("rr_async_addr", if4.Paddr, 0);
    if4.Pready = 1'b1; if4.Pslverr = 1'b0;
    tick();
    chk("rr_no_rsp", if4.rsp_valid, 0);
    reset = 1'b0;
    noise();
    tick();
    chk("rr_after", {if4.rsp_valid, if4.req_ready, if4.Pselx}, {2'b01, 4'b0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/apb_master_ctrl.md
APB_MASTER_CTRL -- requirements
Module: apb_master_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning data width (8, 16 or 32).
REQ-003 SHALL have parameter NUM_SLV, default 4, meaning number of APB slaves (1..16, need not be a power of two).
REQ-004 SHALL have parameter SLV_LSB, default 28, meaning the lowest address bit of the slave-select field, which is $clog2(NUM_SLV) bits wide.
REQ-005 SHALL have parameter TIMEOUT, default 16, meaning the maximum number of ACCESS cycles before abort (>=2).
REQ-006 SHALL use one clock and an asynchronous, active-high reset.
REQ-007 SHALL have port clock, input, 1, system clock, with all flops on its rising edge.
REQ-008 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-009 SHALL have port req_valid, input, 1, transfer request present.
REQ-010 SHALL have port req_ready, output, 1, request accepted this cycle when asserted together with req_valid.
REQ-011 SHALL have port req_addr, input, ADDR_W, transfer address.
REQ-012 SHALL have port req_write, input, 1, 1 = write, 0 = read.
REQ-013 SHALL have port req_wdata, input, DATA_W, write data.
REQ-014 SHALL have port rsp_valid, output, 1, one-cycle completion pulse.
REQ-015 SHALL have port rsp_rdata, output, DATA_W, read data, valid with rsp_valid.
REQ-016 SHALL have port rsp_err, output, 1, error flag (slave error, decode error or timeout), valid with rsp_valid.
REQ-017 SHALL have port Paddr, output, ADDR_W, APB address.
REQ-018 SHALL have port Pwdata, output, DATA_W, APB write data.
REQ-019 SHALL have port Pwrite, output, 1, APB direction.
REQ-020 SHALL have port Pselx, output, NUM_SLV, one-hot slave select.
REQ-021 SHALL have port Penable, output, 1, APB access phase.
REQ-022 SHALL have port Prdata, input, DATA_W, APB read data.
REQ-023 SHALL have port Pready, input, 1, slave ready (wait-state insertion).
REQ-024 SHALL have port Pslverr, input, 1, slave error.

Function
REQ-025 SHALL implement the states IDLE, SETUP, ACCESS and DERR; all outputs are registered.
REQ-026 SHALL drive req_ready=1 only in IDLE, or in ACCESS during the cycle in which the transfer completes (Pready=1).
REQ-027 On acceptance with a decoded index below NUM_SLV, SHALL go to SETUP next cycle: Pselx[idx]=1, Penable=0, Paddr/Pwrite/Pwdata captured.
REQ-028 On acceptance with an index of NUM_SLV or above, SHALL go to DERR: no Pselx bit set, then rsp_valid=1, rsp_err=1, rsp_rdata=0 next cycle, then IDLE.
REQ-029 SHALL always go from SETUP to ACCESS after one cycle (Penable=1), holding Paddr, Pwrite, Pwdata and Pselx stable.
REQ-030 In ACCESS with Pready=1, SHALL complete the transfer: next cycle rsp_valid=1, rsp_err=Pslverr, rsp_rdata=Prdata for a read and 0 for a write.
REQ-031 On the completing cycle with req_valid=1, SHALL go directly to SETUP (back-to-back); Penable SHALL drop for at least that one cycle.
REQ-032 On the completing cycle with req_valid=0, SHALL go to IDLE and clear Pselx and Penable.
REQ-033 SHALL count cycles in ACCESS with a wait counter that resets at each SETUP.
REQ-034 When the wait counter reaches TIMEOUT-1 with Pready=0, SHALL abort: clear Pselx/Penable next cycle, rsp_valid=1, rsp_err=1, rsp_rdata=0, then IDLE.
REQ-035 Pready at the timeout cycle SHALL take precedence over the abort, giving a normal completion.
REQ-036 Minimum latency SHALL be: accept at N, SETUP N+1, ACCESS N+2, rsp_valid N+3.
REQ-037 Pslverr and Prdata SHALL be ignored outside ACCESS with Pready=1.

Reset
REQ-038 Reset SHALL set state=IDLE, req_ready=0, rsp_valid=0, rsp_err=0, and rsp_rdata, Paddr, Pwdata, Pwrite, Pselx, Penable and the wait counter to 0.
REQ-039 req_ready SHALL assert on the first clock edge after reset deasserts.
REQ-040 Reset asserted mid-transfer SHALL drop Pselx/Penable asynchronously, and no rsp_valid SHALL be generated for the aborted transfer.

Structure
REQ-041 Package apb_pkg SHALL hold the state enum (IDLE, SETUP, ACCESS, DERR) and the default parameter constants.
REQ-042 SHALL contain one sub-module, apb_addr_decode: combinational, req_addr to one-hot select plus decode-error flag, parametrised by NUM_SLV and SLV_LSB.

Verification
REQ-043 SHALL verify a zero-wait write: write 0x1000_0040, data 0xDEAD_BEEF, Pready=1 -> Pselx=4'b0010 N+1, Penable N+2, rsp_valid N+3, rsp_err=0.
REQ-044 SHALL verify a read with 3 wait states: read 0x2000_0000, Pready low 3 ACCESS cycles, Prdata=0x1234_5678 -> rsp_rdata=0x1234_5678 at N+6.
REQ-045 SHALL verify a slave error: Pslverr=1 with Pready=1 -> rsp_err=1, and the next request is still accepted.
REQ-046 SHALL verify a timeout: Pready held 0, TIMEOUT=16 -> Pselx clears after 16 ACCESS cycles, rsp_err=1, rsp_rdata=0.
REQ-047 SHALL verify a decode error: NUM_SLV=3, address 0x3000_0000 -> Pselx stays 0, rsp_err=1 two cycles after acceptance.
REQ-048 SHALL verify back-to-back transfers and reset: two writes back-to-back -> no idle cycle, Penable low for 1 cycle between them; reset asserted in ACCESS -> all outputs 0 immediately, no rsp_valid.
